// File: rtl/i2c_fe_pkg.sv
// Shared constants, timeout state encoding and width helper for the I2C pad-side front end.
package i2c_fe_pkg;

  localparam int unsigned SYNC_STAGES_DEF    = 2;
  localparam int unsigned GLITCH_CYCLES_DEF  = 3;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1_250_000;

  typedef enum logic [1:0] {
    TMO_IDLE  = 2'd0,
    TMO_COUNT = 2'd1,
    TMO_TRIP  = 2'd2
  } tmo_state_t;

  // Bits needed to hold the values 0..limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One pad line: reset-high synchronizer chain followed by a stability-count deglitcher.
module i2c_line_filter
  import i2c_fe_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic toggle
);

  localparam int unsigned GW = cnt_width(GLITCH_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GLITCH_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [GW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // High in the cycle before level takes the synchronized value, so the top can register strobes that line up with it.
  assign toggle = (synced != level) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      if (toggle) begin
        level <= synced;
        cnt   <= '0;
      end else if (synced != level) begin
        cnt <= cnt + GW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_frontend.sv
// SCL/SDA conditioning, edge and START/STOP strobes, bus-busy tracking and SDA open-drain enable.
// Optional SMBus-style low-SCL timeout with SDA lockout is built when I2C_TIMEOUT_EN is defined.
module i2c_bus_frontend
  import i2c_fe_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned GLITCH_CYCLES  = GLITCH_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic RST,
  input  logic scl_in,
  input  logic sda_in,
  input  logic sda_drive_low,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic sda_oe,
  output logic timeout
);

  logic scl_tog, sda_tog;
  logic start_now, stop_now;
  logic trip_now;
  logic lockout, lockout_next;
  tmo_state_t tmo_state;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_scl_filter (
    .clk(clk), .rst(RST), .pin(scl_in), .level(scl_f), .toggle(scl_tog)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_sda_filter (
    .clk(clk), .rst(RST), .pin(sda_in), .level(sda_f), .toggle(sda_tog)
  );

  // START/STOP need SCL high and steady; a coincident SCL change makes it a plain clock edge.
  assign start_now = sda_tog &  sda_f & ~scl_tog & scl_f;
  assign stop_now  = sda_tog & ~sda_f & ~scl_tog & scl_f;

`ifdef I2C_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt, cnt_inc;
  logic          low_hold;

  assign low_hold     = bus_busy & ~scl_f;
  assign cnt_inc      = (tmo_cnt >= LIM) ? LIM : tmo_cnt + TW'(1);
  assign trip_now     = (tmo_state != TMO_TRIP) && low_hold && (cnt_inc >= LIM);
  assign lockout_next = start_now ? 1'b0 : (trip_now ? 1'b1 : lockout);

  always_ff @(posedge clk) begin
    if (RST) begin
      tmo_state <= TMO_IDLE;
      tmo_cnt   <= '0;
      timeout   <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      lockout <= lockout_next;
      case (tmo_state)
        TMO_IDLE, TMO_COUNT: begin
          if (!low_hold) begin
            tmo_state <= TMO_IDLE;
            tmo_cnt   <= '0;
          end else if (trip_now) begin
            tmo_state <= TMO_TRIP;
            tmo_cnt   <= '0;
            timeout   <= 1'b1;
          end else begin
            tmo_state <= TMO_COUNT;
            tmo_cnt   <= cnt_inc;
          end
        end
        TMO_TRIP: begin
          tmo_state <= TMO_IDLE;
          tmo_cnt   <= '0;
        end
        default: begin
          tmo_state <= TMO_IDLE;
          tmo_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign tmo_state    = TMO_IDLE;
  assign trip_now     = 1'b0;
  assign lockout      = 1'b0;
  assign lockout_next = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      scl_rise  <= scl_tog & ~scl_f;
      scl_fall  <= scl_tog &  scl_f;
      start_det <= start_now;
      stop_det  <= stop_now;
      if (start_now) begin
        bus_busy <= 1'b1;
      end else if (stop_now || trip_now) begin
        bus_busy <= 1'b0;
      end
      // Uses the next lockout so the enable drops in the same cycle timeout pulses.
      sda_oe <= sda_drive_low & ~lockout_next;
    end
  end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for i2c_bus_frontend: strobes are checked by a scoreboard against an expected event queue.
module tb_i2c_bus_frontend;

  localparam int TO = 100;

  localparam logic [4:0] EV_RISE  = 5'b00001;
  localparam logic [4:0] EV_FALL  = 5'b00010;
  localparam logic [4:0] EV_START = 5'b00100;
  localparam logic [4:0] EV_STOP  = 5'b01000;
  localparam logic [4:0] EV_TMO   = 5'b10000;

  logic clk = 1'b0;
  logic RST, scl_in, sda_in, sda_drive_low;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, sda_oe, timeout;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int t;
  logic [36:0] exp_q[$];

  i2c_bus_frontend #(.SYNC_STAGES(2), .GLITCH_CYCLES(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .RST(RST), .scl_in(scl_in), .sda_in(sda_in), .sda_drive_low(sda_drive_low),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy), .sda_oe(sda_oe),
    .timeout(timeout)
  );

  // clock / reset
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(20 * 20000);
    $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic expect_ev(input int dly, input logic [4:0] v);
    exp_q.push_back({32'(cyc + dly), v});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [4:0]  v;
    logic [36:0] e;
    while (exp_q.size() > 0 && int'(exp_q[0][36:5]) < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_strobe: got none expected %b at cycle %0d", e[4:0], e[36:5]);
    end
    v = {timeout, stop_det, start_det, scl_fall, scl_rise};
    if (v !== 5'b00000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got %b at cycle %0d expected none", v, cyc);
      end else begin
        e = exp_q.pop_front();
        if (v !== e[4:0] || cyc != int'(e[36:5])) begin
          failures++;
          $display("FAIL strobe: got %b at cycle %0d expected %b at cycle %0d", v, cyc, e[4:0], e[36:5]);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; scl_in = 1'b1; sda_in = 1'b1; sda_drive_low = 1'b0;
    step(2);
    @(negedge clk);
    check("scl_f_in_reset", scl_f, 1);
    check("sda_f_in_reset", sda_f, 1);
    step(1);
    RST = 1'b0;
    step(2);
    @(negedge clk);
    check("scl_f_idle", scl_f, 1);
    check("sda_f_idle", sda_f, 1);
    check("busy_idle", bus_busy, 0);
    check("oe_idle", sda_oe, 0);

    // START, then SCL low
    step(1); t = cyc; sda_in = 1'b0; expect_ev(5, EV_START);
    goto(t + 5); @(negedge clk);
    check("sda_f_after_start", sda_f, 0);
    check("busy_after_start", bus_busy, 1);
    step(1); t = cyc; scl_in = 1'b0; expect_ev(5, EV_FALL);
    goto(t + 6); @(negedge clk);
    check("scl_f_low", scl_f, 0);

    // drive-low request to output enable
    step(1); sda_drive_low = 1'b1;
    step(1); @(negedge clk);
    check("oe_follow_high", sda_oe, 1);
    step(1); sda_drive_low = 1'b0;
    step(1); @(negedge clk);
    check("oe_follow_low", sda_oe, 0);

    // SCL high, then STOP
    step(1); t = cyc; scl_in = 1'b1; expect_ev(5, EV_RISE);
    goto(t + 6);
    t = cyc; sda_in = 1'b1; expect_ev(5, EV_STOP);
    goto(t + 5); @(negedge clk);
    check("busy_after_stop", bus_busy, 0);
    check("sda_f_after_stop", sda_f, 1);

    // 2-cycle SDA glitch is rejected
    step(2); t = cyc; sda_in = 1'b0;
    goto(t + 2); sda_in = 1'b1;
    goto(t + 10); @(negedge clk);
    check("sda_f_glitch", sda_f, 1);
    check("busy_glitch", bus_busy, 0);

    // 3-cycle pulse passes: START then STOP
    step(1); t = cyc; sda_in = 1'b0; expect_ev(5, EV_START); expect_ev(8, EV_STOP);
    goto(t + 3); sda_in = 1'b1;
    goto(t + 10); @(negedge clk);
    check("busy_pulse3", bus_busy, 0);

    // simultaneous SCL/SDA change: clock edge only
    step(1); t = cyc; scl_in = 1'b0; sda_in = 1'b0; expect_ev(5, EV_FALL);
    goto(t + 8); @(negedge clk);
    check("scl_f_simul_low", scl_f, 0);
    check("sda_f_simul_low", sda_f, 0);
    check("busy_simul_low", bus_busy, 0);
    step(1); t = cyc; scl_in = 1'b1; sda_in = 1'b1; expect_ev(5, EV_RISE);
    goto(t + 8); @(negedge clk);
    check("busy_simul_high", bus_busy, 0);
    check("sda_f_simul_high", sda_f, 1);

    // busy bus with SCL held low
    step(1); t = cyc; sda_in = 1'b0; expect_ev(5, EV_START);
    goto(t + 7);
    t = cyc; scl_in = 1'b0; sda_drive_low = 1'b1; expect_ev(5, EV_FALL);
`ifdef I2C_TIMEOUT_EN
    expect_ev(5 + TO, EV_TMO);
    goto(t + 4 + TO); @(negedge clk);
    check("oe_before_trip", sda_oe, 1);
    check("busy_before_trip", bus_busy, 1);
    step(1); @(negedge clk);
    check("oe_at_trip", sda_oe, 0);
    check("busy_at_trip", bus_busy, 0);
    goto(t + 10 + TO); @(negedge clk);
    check("oe_lockout", sda_oe, 0);
`else
    goto(t + 30 + TO); @(negedge clk);
    check("busy_no_timeout", bus_busy, 1);
    check("oe_no_timeout", sda_oe, 1);
    check("timeout_tied_low", timeout, 0);
`endif
    step(1); t = cyc; scl_in = 1'b1; expect_ev(5, EV_RISE);
    goto(t + 7);
    t = cyc; sda_in = 1'b1; expect_ev(5, EV_STOP);
    goto(t + 7); @(negedge clk);
`ifdef I2C_TIMEOUT_EN
    check("oe_lockout_after_stop", sda_oe, 0);
`else
    check("oe_after_stop", sda_oe, 1);
`endif
    step(1); t = cyc; sda_in = 1'b0; expect_ev(5, EV_START);
    goto(t + 5); @(negedge clk);
    check("busy_restart", bus_busy, 1);
    step(1); @(negedge clk);
    check("oe_after_restart", sda_oe, 1);

    // reset in the middle of a byte
    step(1); t = cyc; scl_in = 1'b0; expect_ev(5, EV_FALL);
    goto(t + 7); scl_in = 1'b1;
    goto(t + 9); RST = 1'b1; sda_in = 1'b1;
    step(1); @(negedge clk);
    check("scl_f_mid_rst", scl_f, 1);
    check("sda_f_mid_rst", sda_f, 1);
    check("busy_mid_rst", bus_busy, 0);
    check("oe_mid_rst", sda_oe, 0);
    check("timeout_mid_rst", timeout, 0);
    step(1); RST = 1'b0; sda_drive_low = 1'b0;
    t = cyc;
    goto(t + 10); @(negedge clk);
    check("busy_after_rst", bus_busy, 0);

    // fresh transaction after reset
    step(1); t = cyc; sda_in = 1'b0; expect_ev(5, EV_START);
    goto(t + 6); @(negedge clk);
    check("busy_post_rst_start", bus_busy, 1);
    step(1); t = cyc; sda_in = 1'b1; expect_ev(5, EV_STOP);
    goto(t + 8); @(negedge clk);
    check("busy_post_rst_stop", bus_busy, 0);

    step(5); @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
